cpu_system_top: RTL and testbench

- Minimal single-clock 6502-subset system: a small CPU core, a 4 KB ROM at 0xF000–0xFFFF and a RAM at 0x0000.
- Serves as the regression vehicle for jump, subroutine and return flow.
- Verification observes RAM through a debug read port.

---
 rtl/cpu_system_top.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu_system_top.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_system_top.sv
// Minimal 6502-subset system: CPU core, 4 KB ROM at 0xF000-0xFFFF and RAM at 0x0000.
// Build option: define CPU_INDEXED_STORE_EN to decode STA zp,X (0x95) and INX (0xE8).
module cpu_system_top #(
  parameter int    RAM_AW        = 11,
  parameter string ROM_INIT_FILE = ""
) (
  input  logic              ph1,
  input  logic              resetb,
  input  logic [RAM_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data,
  output logic [15:0]       pc_out,
  output logic              halted
);

  typedef enum logic [4:0] {
    S_RST0, S_RST1, S_FETCH, S_IMM,
    S_ZP_LO, S_ZPX_ADD, S_ZP_WR,
    S_ABS_LO, S_ABS_HI, S_ABS_WR, S_JMP_HI,
    S_NOP,
    S_JSR_LO, S_JSR_INT, S_JSR_PCH, S_JSR_PCL, S_JSR_HI,
    S_RTS_DUMMY, S_RTS_INC, S_RTS_PCL, S_RTS_PCH, S_RTS_INCPC,
    S_INX, S_HALT
  } state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_x;
  logic [7:0]  r_sp;
  logic [15:0] r_pc;
  logic        r_n;
  logic        r_z;
  logic        r_halted;
  logic [7:0]  r_op;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;

  logic [7:0]  r_rom [4096];
  logic [7:0]  r_ram [2**RAM_AW];

  logic [15:0] w_addr;
  logic        w_we;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rdata;
  logic        w_is_ram;
  logic        w_is_rom;

  // ROM image starts all zero.
  initial begin
    for (int i = 0; i < 4096; i++) r_rom[i] = 8'h00;
  end

  // Single bus: the current state alone selects address, direction and write data.
  always_comb begin
    w_addr  = r_pc;
    w_we    = 1'b0;
    w_wdata = r_a;
    case (r_state)
      S_RST0:   w_addr = 16'hFFFC;
      S_RST1:   w_addr = 16'hFFFD;
      S_ZP_WR:  begin w_addr = {8'h00, r_lo}; w_we = 1'b1; end
      S_ABS_WR: begin w_addr = {r_hi, r_lo};  w_we = 1'b1; end
      S_JSR_PCH: begin
        w_addr  = {8'h01, r_sp};
        w_we    = 1'b1;
        w_wdata = r_pc[15:8];
      end
      S_JSR_PCL: begin
        w_addr  = {8'h01, r_sp};
        w_we    = 1'b1;
        w_wdata = r_pc[7:0];
      end
      S_RTS_PCL, S_RTS_PCH: w_addr = {8'h01, r_sp};
      default: ;
    endcase
  end

  assign w_is_ram = (w_addr >> RAM_AW) == 16'd0;
  assign w_is_rom = (w_addr[15:12] == 4'hF);

  always_comb begin
    w_rdata = 8'hFF;
    if (w_is_ram)      w_rdata = r_ram[w_addr[RAM_AW-1:0]];
    else if (w_is_rom) w_rdata = r_rom[w_addr[11:0]];
  end

  // Gating on resetb keeps a write from landing on the edge that reset interrupts.
  always_ff @(posedge ph1) begin
    if (resetb && w_we && w_is_ram) r_ram[w_addr[RAM_AW-1:0]] <= w_wdata;
  end

  assign dbg_data = r_ram[dbg_addr];
  assign pc_out   = r_pc;
  assign halted   = r_halted;

  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      r_state  <= S_RST0;
      r_a      <= 8'h00;
      r_x      <= 8'h00;
      r_sp     <= 8'hFF;
      r_pc     <= 16'h0000;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_halted <= 1'b0;
      r_op     <= 8'h00;
      r_lo     <= 8'h00;
      r_hi     <= 8'h00;
    end else begin
      case (r_state)
        S_RST0: begin
          r_pc[7:0] <= w_rdata;
          r_state   <= S_RST1;
        end
        S_RST1: begin
          r_pc[15:8] <= w_rdata;
          r_state    <= S_FETCH;
        end
        S_FETCH: begin
          r_op <= w_rdata;
          r_pc <= r_pc + 16'd1;
          case (w_rdata)
            8'hA9, 8'hA2: r_state <= S_IMM;
            8'h85:        r_state <= S_ZP_LO;
            8'h8D, 8'h4C: r_state <= S_ABS_LO;
            8'hEA:        r_state <= S_NOP;
            8'h20:        r_state <= S_JSR_LO;
            8'h60:        r_state <= S_RTS_DUMMY;
`ifdef CPU_INDEXED_STORE_EN
            8'h95:        r_state <= S_ZP_LO;
            8'hE8:        r_state <= S_INX;
`endif
            default: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          endcase
        end
        S_IMM: begin
          if (r_op == 8'hA2) r_x <= w_rdata;
          else               r_a <= w_rdata;
          r_n     <= w_rdata[7];
          r_z     <= (w_rdata == 8'h00);
          r_pc    <= r_pc + 16'd1;
          r_state <= S_FETCH;
        end
        S_ZP_LO: begin
          r_lo    <= w_rdata;
          r_pc    <= r_pc + 16'd1;
          r_state <= (r_op == 8'h95) ? S_ZPX_ADD : S_ZP_WR;
        end
        S_ZPX_ADD: begin
          r_lo    <= r_lo + r_x;
          r_state <= S_ZP_WR;
        end
        S_ZP_WR:  r_state <= S_FETCH;
        S_ABS_LO: begin
          r_lo    <= w_rdata;
          r_pc    <= r_pc + 16'd1;
          r_state <= (r_op == 8'h4C) ? S_JMP_HI : S_ABS_HI;
        end
        S_ABS_HI: begin
          r_hi    <= w_rdata;
          r_pc    <= r_pc + 16'd1;
          r_state <= S_ABS_WR;
        end
        S_ABS_WR: r_state <= S_FETCH;
        S_JMP_HI: begin
          r_pc    <= {w_rdata, r_lo};
          r_state <= S_FETCH;
        end
        S_NOP:    r_state <= S_FETCH;
        // PC is left on JSR's last byte so the pushed return address points there.
        S_JSR_LO: begin
          r_lo    <= w_rdata;
          r_pc    <= r_pc + 16'd1;
          r_state <= S_JSR_INT;
        end
        S_JSR_INT: r_state <= S_JSR_PCH;
        S_JSR_PCH: begin
          r_sp    <= r_sp - 8'd1;
          r_state <= S_JSR_PCL;
        end
        S_JSR_PCL: begin
          r_sp    <= r_sp - 8'd1;
          r_state <= S_JSR_HI;
        end
        S_JSR_HI: begin
          r_pc    <= {w_rdata, r_lo};
          r_state <= S_FETCH;
        end
        S_RTS_DUMMY: r_state <= S_RTS_INC;
        S_RTS_INC: begin
          r_sp    <= r_sp + 8'd1;
          r_state <= S_RTS_PCL;
        end
        S_RTS_PCL: begin
          r_lo    <= w_rdata;
          r_sp    <= r_sp + 8'd1;
          r_state <= S_RTS_PCH;
        end
        S_RTS_PCH: begin
          r_pc    <= {w_rdata, r_lo};
          r_state <= S_RTS_INCPC;
        end
        S_RTS_INCPC: begin
          r_pc    <= r_pc + 16'd1;
          r_state <= S_FETCH;
        end
        S_INX: begin
          r_x     <= r_x + 8'd1;
          r_n     <= r_x[7] ^ (r_x[6:0] == 7'h7F);
          r_z     <= (r_x == 8'hFF);
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_system_top.sv
// Self-checking bench for cpu_system_top: reset vector, JSR/RTS flow, STA abs/flags,
// halt on unknown opcode, reset mid-JSR and the optional indexed store.
module tb_cpu_system_top;

  localparam int RAM_AW = 11;

  logic              ph1;
  logic              resetb;
  logic [RAM_AW-1:0] dbg_addr;
  logic [7:0]        dbg_data;
  logic [15:0]       pc_out;
  logic              halted;

  cpu_system_top #(.RAM_AW(RAM_AW)) dut (
    .ph1      (ph1),
    .resetb   (resetb),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .pc_out   (pc_out),
    .halted   (halted)
  );

  // clock / reset
  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard
  task automatic sb_expect(input string tag, input logic [15:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic sb_observe(input logic [15:0] got);
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", got, 16'hDEAD);
    end else begin
      check_eq(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  // drivers
  task automatic cycles(input int n);
    repeat (n) @(negedge ph1);
  endtask

  task automatic hold_reset();
    @(negedge ph1);
    resetb = 1'b0;
  endtask

  task automatic release_reset();
    cycles(2);
    resetb = 1'b1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 4096; i++) dut.r_rom[i] = 8'h00;
  endtask

  task automatic rom_load(input logic [11:0] base, input logic [7:0] bytes[$]);
    logic [11:0] a;
    a = base;
    foreach (bytes[i]) begin
      dut.r_rom[a] = bytes[i];
      a = a + 12'd1;
    end
  endtask

  task automatic set_vector(input logic [15:0] v);
    dut.r_rom[12'hFFC] = v[7:0];
    dut.r_rom[12'hFFD] = v[15:8];
  endtask

  function automatic logic [7:0] ram_peek(input logic [RAM_AW-1:0] a);
    dbg_addr = a;
    return dbg_data;
  endfunction

  task automatic ram_observe(input logic [RAM_AW-1:0] a);
    dbg_addr = a;
    #1;
    sb_observe({8'h00, dbg_data});
  endtask

  // count of samples where pc_out leaves [lo,hi] over n cycles
  task automatic pc_range(input int n, input logic [15:0] lo, input logic [15:0] hi,
                          output int bad, output int hits_lo);
    bad = 0;
    hits_lo = 0;
    for (int i = 0; i < n; i++) begin
      cycles(1);
      if (pc_out < lo || pc_out > hi) bad++;
      if (pc_out == lo) hits_lo++;
    end
  endtask

  int bad;
  int hits;

  initial begin
    resetb   = 1'b0;
    dbg_addr = '0;
    #1;

    // 1: reset vector and spin loop
    hold_reset();
    rom_clear();
    set_vector(16'hF000);
    rom_load(12'h000, '{8'hEA, 8'h4C, 8'h01, 8'hF0});
    sb_expect("rst_pc", 16'h0000);
    sb_expect("rst_halted", 16'h0000);
    sb_expect("rst_sp", 16'h00FF);
    sb_expect("rst_a", 16'h0000);
    sb_expect("cyc2_pc", 16'h0000);
    sb_expect("cyc3_pc", 16'hF000);
    sb_expect("spin_range_bad", 16'd0);
    sb_expect("spin_halted", 16'h0000);
    cycles(1);
    sb_observe(pc_out);
    sb_observe({15'd0, halted});
    sb_observe({8'h00, dut.r_sp});
    sb_observe({8'h00, dut.r_a});
    release_reset();
    cycles(1);
    sb_observe(pc_out);
    cycles(1);
    sb_observe(pc_out);
    pc_range(20, 16'hF001, 16'hF003, bad, hits);
    sb_observe(bad[15:0]);
    sb_observe({15'd0, halted});

    // 2: JSR / subroutine / RTS
    hold_reset();
    rom_clear();
    set_vector(16'hF000);
    rom_load(12'h000, '{8'h20, 8'h10, 8'hF0, 8'h4C, 8'h03, 8'hF0});
    rom_load(12'h010, '{8'hA9, 8'h42, 8'h85, 8'h40, 8'h60});
    sb_expect("jsr_pc_sub", 16'hF010);
    sb_expect("rts_pc_ret", 16'hF003);
    sb_expect("ram_040", 16'h0042);
    sb_expect("ram_1ff", 16'h00F0);
    sb_expect("ram_1fe", 16'h0002);
    sb_expect("rts_sp", 16'h00FF);
    sb_expect("loop_range_bad", 16'd0);
    sb_expect("loop_hits_f003", 16'd1);
    release_reset();
    cycles(8);
    sb_observe(pc_out);
    cycles(11);
    sb_observe(pc_out);
    cycles(30);
    ram_observe(11'h040);
    ram_observe(11'h1FF);
    ram_observe(11'h1FE);
    sb_observe({8'h00, dut.r_sp});
    pc_range(9, 16'hF003, 16'hF005, bad, hits);
    sb_observe(bad[15:0]);
    sb_observe((hits > 0) ? 16'd1 : 16'd0);

    // 3: STA abs and N/Z flags
    hold_reset();
    rom_clear();
    set_vector(16'hF000);
    rom_load(12'h000, '{8'hA9, 8'h80, 8'h8D, 8'h23, 8'h01, 8'hA9, 8'h00,
                        8'h4C, 8'h07, 8'hF0});
    sb_expect("sta_abs_ram_123", 16'h0080);
    sb_expect("lda80_n", 16'd1);
    sb_expect("lda80_z", 16'd0);
    sb_expect("lda00_z", 16'd1);
    sb_expect("lda00_n", 16'd0);
    sb_expect("lda00_a", 16'h0000);
    release_reset();
    cycles(8);
    ram_observe(11'h123);
    sb_observe({15'd0, dut.r_n});
    sb_observe({15'd0, dut.r_z});
    cycles(2);
    sb_observe({15'd0, dut.r_z});
    sb_observe({15'd0, dut.r_n});
    sb_observe({8'h00, dut.r_a});

    // 4: unknown opcode halts
    hold_reset();
    rom_clear();
    set_vector(16'hF000);
    rom_load(12'h000, '{8'h02, 8'hA9, 8'h11, 8'h85, 8'h40});
    sb_expect("halt_cyc3", 16'd0);
    sb_expect("halt_cyc4", 16'd1);
    sb_expect("halt_pc", 16'hF001);
    sb_expect("halt_pc_frozen", 16'hF001);
    sb_expect("halt_still", 16'd1);
    sb_expect("halt_ram_040", 16'h0042);
    sb_expect("halt_ram_123", 16'h0080);
    release_reset();
    cycles(2);
    sb_observe({15'd0, halted});
    cycles(1);
    sb_observe({15'd0, halted});
    sb_observe(pc_out);
    cycles(20);
    sb_observe(pc_out);
    sb_observe({15'd0, halted});
    ram_observe(11'h040);
    ram_observe(11'h123);

    // 5: reset asserted during JSR's PCH push
    hold_reset();
    rom_clear();
    set_vector(16'hF100);
    rom_load(12'h100, '{8'h20, 8'h10, 8'hF1, 8'h4C, 8'h03, 8'hF1});
    rom_load(12'h110, '{8'h60});
    sb_expect("abort_ram_1ff", 16'h00F0);
    sb_expect("abort_ram_1fe", 16'h0002);
    sb_expect("abort_sp", 16'h00FF);
    sb_expect("abort_pc", 16'h0000);
    sb_expect("restart_pc", 16'hF100);
    sb_expect("restart_sub_pc", 16'hF110);
    sb_expect("restart_ram_1ff", 16'h00F1);
    sb_expect("restart_ram_1fe", 16'h0002);
    release_reset();
    cycles(5);
    resetb = 1'b0;
    cycles(2);
    ram_observe(11'h1FF);
    ram_observe(11'h1FE);
    sb_observe({8'h00, dut.r_sp});
    sb_observe(pc_out);
    resetb = 1'b1;
    cycles(2);
    sb_observe(pc_out);
    cycles(6);
    sb_observe(pc_out);
    cycles(10);
    ram_observe(11'h1FF);
    ram_observe(11'h1FE);

    // 6: indexed store with zero-page wrap, or halt when the option is absent
    hold_reset();
    rom_clear();
    set_vector(16'hF000);
    rom_load(12'h000, '{8'hA9, 8'h3C, 8'h85, 8'h15, 8'hA2, 8'hC5, 8'hA9, 8'h77,
                        8'h95, 8'h50, 8'h4C, 8'h0A, 8'hF0});
`ifdef CPU_INDEXED_STORE_EN
    sb_expect("zpx_ram_015", 16'h0077);
    sb_expect("zpx_halted", 16'd0);
    sb_expect("zpx_x", 16'h00C5);
`else
    sb_expect("no_zpx_ram_015", 16'h003C);
    sb_expect("no_zpx_halted", 16'd1);
    sb_expect("no_zpx_pc", 16'hF009);
`endif
    release_reset();
    cycles(40);
    ram_observe(11'h015);
    sb_observe({15'd0, halted});
`ifdef CPU_INDEXED_STORE_EN
    sb_observe({8'h00, dut.r_x});
`else
    sb_observe(pc_out);
`endif

    check_eq("sb_drain", exp_q.size(), 16'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
